// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline.
// Derives PC and pipeline-register enables/flushes from cache status, load-use
// hazards, MEM-stage redirects and halt progress. It also owns the halt-drain
// sequence and two saturating performance counters.
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | normal operation, hazard priority mem_busy > redirect > halt > load_use > ~ihit
// DRAIN  | halt seen in EX; younger instructions are killed until halt reaches WB
// HALTED | processor stopped; everything frozen until reset
//
// A cycle counts as a stall whenever the PC is held outside HALTED (mem_busy,
// load_use, ~ihit, and the drain cycles including the DRAIN entry cycle).

module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dREN_EX_MEM,
    input  logic             dWEN_EX_MEM,
    input  logic             dREN_ID_EX,
    input  logic [4:0]       Rt_ID_EX,
    input  logic [4:0]       Rs_IF_ID,
    input  logic [4:0]       Rt_IF_ID,
    input  logic             redirect_EX_MEM,
    input  logic             halt_ID_EX,
    input  logic             halt_MEM_WB,
    output logic             pc_enable,
    output logic             enable_IF_ID,
    output logic             enable_ID_EX,
    output logic             enable_EX_MEM,
    output logic             enable_MEM_WB,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             flush_EX_MEM,
    output logic             flush_MEM_WB,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic mem_busy;
    logic load_use;
    logic stall_sel;
    logic flush_sel;

    assign mem_busy = (dREN_EX_MEM | dWEN_EX_MEM) & ~dhit;
    assign load_use = dREN_ID_EX & (Rt_ID_EX != 5'd0) &
                      ((Rt_ID_EX == Rs_IF_ID) | (Rt_ID_EX == Rt_IF_ID));

    // Next state and pipeline controls, highest-priority hazard wins.
    always_comb begin
        pc_enable     = 1'b1;
        enable_IF_ID  = 1'b1;
        enable_ID_EX  = 1'b1;
        enable_EX_MEM = 1'b1;
        enable_MEM_WB = 1'b1;
        flush_IF_ID   = 1'b0;
        flush_ID_EX   = 1'b0;
        flush_EX_MEM  = 1'b0;
        flush_MEM_WB  = 1'b0;
        stall_sel     = 1'b0;
        flush_sel     = 1'b0;
        state_d       = state_q;

        case (state_q)
            RUN, DRAIN: begin
                if (mem_busy) begin
                    // freeze everything upstream of MEM, bubble into WB
                    pc_enable     = 1'b0;
                    enable_IF_ID  = 1'b0;
                    enable_ID_EX  = 1'b0;
                    enable_EX_MEM = 1'b0;
                    flush_MEM_WB  = 1'b1;
                    stall_sel     = 1'b1;
                end else if (redirect_EX_MEM) begin
                    // target is loaded even if the fetch is still pending;
                    // a halt in ID/EX is squashed with the rest
                    flush_IF_ID   = 1'b1;
                    flush_ID_EX   = 1'b1;
                    flush_EX_MEM  = 1'b1;
                    flush_sel     = 1'b1;
                end else if ((state_q == DRAIN) || halt_ID_EX) begin
                    pc_enable     = 1'b0;
                    flush_IF_ID   = 1'b1;
                    flush_ID_EX   = 1'b1;
                    stall_sel     = 1'b1;
                    if (state_q == RUN) begin
                        state_d = DRAIN;
                    end
                end else if (load_use) begin
                    // one bubble: the load leaves EX on this edge
                    pc_enable     = 1'b0;
                    enable_IF_ID  = 1'b0;
                    flush_ID_EX   = 1'b1;
                    stall_sel     = 1'b1;
                end else if (!ihit) begin
                    pc_enable     = 1'b0;
                    flush_IF_ID   = 1'b1;
                    stall_sel     = 1'b1;
                end

                if ((state_q == DRAIN) && halt_MEM_WB) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                pc_enable     = 1'b0;
                enable_IF_ID  = 1'b0;
                enable_ID_EX  = 1'b0;
                enable_EX_MEM = 1'b0;
                enable_MEM_WB = 1'b0;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Saturating counters and registered halt flag.
    always_comb begin
        halted_d      = (state_d == HALTED);
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_sel && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
        if (flush_sel && (flush_count_q != {CNT_W{1'b1}})) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    // State and counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= RUN;
            halted_q      <= 1'b0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            halted_q      <= halted_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign halted      = halted_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule
